// File: rtl/instr_mem_loader_if.sv
// Bus bundle for instr_mem_loader: load control, upstream byte stream,
// instruction-memory write port and status.
//   master : load requester / byte source / memory + status observer
//   slave  : the loader itself
interface instr_mem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] last_addr;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [71:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, last_addr, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
    );

    modport slave (
        input  start, last_addr, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
    );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams bytes into 72-bit instruction words (MSB-first,
// 9 bytes per word) and writes them to consecutive instruction-memory
// addresses 0..last_addr, holding the CPU in reset while loading.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - instr_mem_loader_if.slave: start/last_addr, byte_valid/byte_data/
//          byte_ready, mem_we/mem_addr/mem_wdata, cpu_hold, busy, done, err
//
// Optional feature: define LOADER_CHECKSUM_EN to add the CHECK state, which
// accepts one trailing byte and flags err when it differs from the XOR of
// all data bytes of the load. Without it err is tied low.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; last_addr captured on accept
// COLLECT | accepting the 9 bytes of the current word
// WRITE   | one-cycle memory write of the assembled word
// CHECK   | accepting the checksum byte (LOADER_CHECKSUM_EN only)
// DONE    | one-cycle done pulse, then back to IDLE
module instr_mem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    instr_mem_loader_if.slave bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK   = 3'd4;
`endif

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [71:0]       word_q, word_d;
    logic              byte_ready;
    logic              accept;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
    logic              err_q, err_d;
    assign byte_ready = (state_q == S_COLLECT) || (state_q == S_CHECK);
`else
    assign byte_ready = (state_q == S_COLLECT);
`endif

    assign accept = bus.byte_valid && byte_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d   = xor_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    last_d  = bus.last_addr;
                    addr_d  = '0;
                    cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    xor_d   = '0;
                    err_d   = 1'b0;
`endif
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    // Shift left so the first byte ends up in 71:64.
                    word_d = {word_q[63:0], bus.byte_data};
`ifdef LOADER_CHECKSUM_EN
                    xor_d  = xor_q ^ bus.byte_data;
`endif
                    if (cnt_q == 4'd8) begin
                        state_d = S_WRITE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_WRITE: begin
                // Terminate on equality before incrementing, so the
                // address counter can never wrap past all-ones.
                if (addr_q != last_q) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    cnt_d   = '0;
                    state_d = S_COLLECT;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    err_d   = (bus.byte_data != xor_q);
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.mem_we     = (state_q == S_WRITE);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = word_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.cpu_hold   = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
`ifdef LOADER_CHECKSUM_EN
    assign bus.err        = err_q;
`else
    assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_mem_loader_if #(.ADDR_W(8)) bus ();
    instr_mem_loader #(.ADDR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [7:0]  addr;
        logic [71:0] data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   wr_cnt = 0;
    logic in_load = 1'b0;
    logic hold_drop = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write scoreboard, done counter and cpu_hold watcher.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexp_we", 72'd1, 72'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 72'(bus.mem_addr), 72'(mon_e.addr));
                check("wr_data", bus.mem_wdata, mon_e.data);
            end
        end
        if (bus.done === 1'b1) done_cnt++;
        if (in_load && bus.cpu_hold !== 1'b1) hold_drop = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] last, output int p);
        p = cyc;
        bus.start = 1'b1;
        bus.last_addr = last;
        tick();
        bus.start = 1'b0;
        in_load = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit r;
        int n;
        n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data = b;
        do begin
            @(negedge clk);
            r = bus.byte_ready;
            tick();
            n++;
        end while (!r && n < 50);
        if (!r) check("byte_accept_timeout", 72'd0, 72'd1);
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'hEE;
        if (gap) tick();
    endtask

    // Sends nb bytes base, base+1, ...; pushes the full word only if asked.
    task automatic send_word(input logic [7:0] addr, input logic [7:0] base, input bit gap,
                             input bit push, input int nb, inout logic [7:0] x);
        logic [71:0] w;
        wr_t t;
        w = '0;
        for (int j = 0; j < 9; j++) w = {w[63:0], 8'(base + j)};
        if (push) begin
            t.addr = addr;
            t.data = w;
            exp_q.push_back(t);
        end
        for (int j = 0; j < nb; j++) begin
            x = x ^ 8'(base + j);
            send_byte(8'(base + j), gap);
        end
    endtask

    task automatic finish_load(input logic [7:0] x);
`ifdef LOADER_CHECKSUM_EN
        send_byte(x, 1'b0);
`else
        if (x === 8'hxx) tick();
`endif
    endtask

    task automatic wait_done(input int lim, output int dc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.done !== 1'b1 && n < lim);
        if (bus.done !== 1'b1) check("done_timeout", 72'd0, 72'd1);
        dc = cyc;
        in_load = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_ready"}, 72'(bus.byte_ready), 72'd0);
        check({tag, "_mem_we"},     72'(bus.mem_we),     72'd0);
        check({tag, "_cpu_hold"},   72'(bus.cpu_hold),   72'd0);
        check({tag, "_busy"},       72'(bus.busy),       72'd0);
        check({tag, "_done"},       72'(bus.done),       72'd0);
        check({tag, "_err"},        72'(bus.err),        72'd0);
        check({tag, "_mem_addr"},   72'(bus.mem_addr),   72'd0);
        check({tag, "_mem_wdata"},  bus.mem_wdata,       72'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, dc;
        logic [7:0] x;

        bus.start = 1'b0;
        bus.last_addr = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // Single word, back-to-back bytes 0x10..0x18.
        done_cnt = 0;
        x = 8'h00;
        do_start(8'h00, p);
        send_word(8'h00, 8'h10, 1'b0, 1'b1, 9, x);
        check("t1_word_const", exp_q.size() == 1 ? exp_q[0].data : 72'd0,
              72'h10_11_12_13_14_15_16_17_18);
        finish_load(x);
        wait_done(40, dc);
        // Start driven in cycle p; 9 collect + 1 write + done = 11 cycles later.
`ifdef LOADER_CHECKSUM_EN
        check("t1_latency", 72'(dc - p), 72'd12);
`else
        check("t1_latency", 72'(dc - p), 72'd11);
`endif
        @(negedge clk);
        check("t1_done_one_cycle", 72'(bus.done), 72'd0);
        check("t1_hold_low", 72'(bus.cpu_hold), 72'd0);
        check("t1_done_cnt", 72'(done_cnt), 72'd1);
        tick();

        // Three words, byte_valid toggling every cycle.
        done_cnt = 0;
        hold_drop = 1'b0;
        x = 8'h00;
        do_start(8'h02, p);
        for (int w = 0; w < 3; w++) send_word(8'(w), 8'(8'h20 + 9 * w), 1'b1, 1'b1, 9, x);
        finish_load(x);
        wait_done(200, dc);
        check("t2_hold_during", 72'(hold_drop), 72'd0);
        check("t2_sb_empty", 72'(exp_q.size()), 72'd0);
        @(negedge clk);
        check("t2_hold_after_done", 72'(bus.cpu_hold), 72'd0);
        check("t2_busy_after_done", 72'(bus.busy), 72'd0);
        check("t2_done_cnt", 72'(done_cnt), 72'd1);
        tick();

        // start / last_addr changes mid-load are ignored.
        done_cnt = 0;
        wr_cnt = 0;
        x = 8'h00;
        do_start(8'h01, p);
        send_word(8'h00, 8'h50, 1'b0, 1'b1, 9, x);
        bus.start = 1'b1;
        bus.last_addr = 8'h05;
        tick();
        bus.start = 1'b0;
        send_word(8'h01, 8'h60, 1'b0, 1'b1, 9, x);
        finish_load(x);
        wait_done(100, dc);
        tick();
        repeat (20) tick();
        check("t3_wr_cnt", 72'(wr_cnt), 72'd2);
        check("t3_done_cnt", 72'(done_cnt), 72'd1);
        check("t3_sb_empty", 72'(exp_q.size()), 72'd0);

        // Reset after 5 bytes of word 1.
        wr_cnt = 0;
        x = 8'h00;
        do_start(8'h02, p);
        send_word(8'h00, 8'h40, 1'b0, 1'b1, 9, x);
        send_word(8'h01, 8'h70, 1'b0, 1'b0, 5, x);
        in_load = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("t4");
        tick();
        repeat (20) tick();
        check("t4_wr_cnt", 72'(wr_cnt), 72'd1);
        check("t4_sb_empty", 72'(exp_q.size()), 72'd0);

        // Full address range, no wrap.
        done_cnt = 0;
        wr_cnt = 0;
        x = 8'h00;
        do_start(8'hFF, p);
        for (int w = 0; w < 256; w++) send_word(8'(w), 8'(w * 3), 1'b0, 1'b1, 9, x);
        finish_load(x);
        wait_done(100, dc);
        check("t5_addr_at_done", 72'(bus.mem_addr), 72'hFF);
        tick();
        repeat (20) tick();
        check("t5_wr_cnt", 72'(wr_cnt), 72'd256);
        check("t5_done_cnt", 72'(done_cnt), 72'd1);
        check("t5_sb_empty", 72'(exp_q.size()), 72'd0);

`ifdef LOADER_CHECKSUM_EN
        // Correct checksum: XOR of 0x00..0x08 is 0x08.
        x = 8'h00;
        do_start(8'h00, p);
        send_word(8'h00, 8'h00, 1'b0, 1'b1, 9, x);
        send_byte(8'h08, 1'b0);
        wait_done(40, dc);
        check("t6_err_good", 72'(bus.err), 72'd0);
        tick();

        // Wrong checksum sets err, which holds until the next start.
        x = 8'h00;
        do_start(8'h00, p);
        send_word(8'h00, 8'h00, 1'b0, 1'b1, 9, x);
        send_byte(8'h09, 1'b0);
        wait_done(40, dc);
        check("t7_err_bad", 72'(bus.err), 72'd1);
        tick();
        repeat (10) tick();
        @(negedge clk);
        check("t7_err_hold", 72'(bus.err), 72'd1);
        tick();
        x = 8'h00;
        do_start(8'h00, p);
        @(negedge clk);
        check("t7_err_cleared", 72'(bus.err), 72'd0);
        tick();
        send_word(8'h00, 8'h00, 1'b0, 1'b1, 9, x);
        send_byte(8'h08, 1'b0);
        wait_done(40, dc);
        check("t7_err_final", 72'(bus.err), 72'd0);
        tick();
`endif

        repeat (5) tick();
        check("final_sb_empty", 72'(exp_q.size()), 72'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
- REQ-001 The block SHALL have one parameter, ADDR_W, default 8, giving the instruction memory address width (depth 2^ADDR_W words).
- REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
- REQ-003 rst  input  1  synchronous, active-high reset.
- REQ-004 start  input  1  load request, sampled only in IDLE.
- REQ-005 last_addr  input  ADDR_W  final word address, captured on an accepted start.
- REQ-006 byte_valid  input  1  upstream byte-stream valid.
- REQ-007 byte_data  input  8  upstream byte.
- REQ-008 byte_ready  output  1  the block can accept a byte.
- REQ-009 mem_we  output  1  instruction memory write strobe.
- REQ-010 mem_addr  output  ADDR_W  instruction memory write address.
- REQ-011 mem_wdata  output  72  instruction word; bits 71:68 are the opcode field.
- REQ-012 cpu_hold  output  1  holds the processor in reset while a load is in progress.
- REQ-013 busy  output  1  the state is not IDLE.
- REQ-014 done  output  1  one-cycle pulse when a load completes.
- REQ-015 err  output  1  checksum mismatch flag (see Configuration).

Function
- REQ-016 The state machine SHALL have the states IDLE, COLLECT, WRITE, CHECK and DONE.
- REQ-017 IDLE: start=1 SHALL capture last_addr, clear the address counter to 0, the byte counter to 0 and err to 0, and go to COLLECT.
- REQ-018 Outside IDLE, start SHALL be ignored.
- REQ-019 A byte SHALL be accepted only on a cycle where byte_valid=1 and byte_ready=1; byte_data SHALL be ignored on every other cycle.
- REQ-020 byte_ready SHALL be 1 only in COLLECT and CHECK.
- REQ-021 Bytes SHALL be assembled MSB-first: the first accepted byte SHALL land in bits 71:64 and the ninth in bits 7:0.
- REQ-022 Acceptance of the ninth byte SHALL move the state to WRITE on the next cycle.
- REQ-023 WRITE SHALL last exactly one cycle and drive mem_we=1, mem_addr = address counter, and mem_wdata = the assembled word.
- REQ-024 mem_we SHALL be 0 in every state except WRITE.
- REQ-025 From WRITE, if the address counter ≠ captured last_addr, the block SHALL increment the counter, clear the byte counter and return to COLLECT.
- REQ-026 From WRITE, if the address counter = captured last_addr, the block SHALL go to CHECK when the macro is defined, and to DONE otherwise.
- REQ-027 The address counter SHALL never wrap: last_addr = 2^ADDR_W−1 writes every word once and then terminates.
- REQ-028 DONE SHALL last one cycle with done=1, then go to IDLE.
- REQ-029 cpu_hold SHALL equal busy: high from the cycle after start is accepted through DONE inclusive, low in IDLE.
- REQ-030 Stalls on byte_valid SHALL cause no timeout and no loss of already-accepted bytes.
- REQ-031 Minimum load latency SHALL be 10 cycles per word plus 1 DONE cycle, with byte_valid held high.

Reset
- REQ-032 rst=1 SHALL force IDLE on the next edge and SHALL take priority over every other input.
- REQ-033 After reset: byte_ready, mem_we, cpu_hold, busy, done and err SHALL be 0; mem_addr SHALL be 0; mem_wdata SHALL be 0.
- REQ-034 Reset during a load SHALL abandon the partial word without a write; words already written SHALL stay in memory.

Configuration
- REQ-035 The macro LOADER_CHECKSUM_EN SHALL enable the checksum feature.
- REQ-036 With LOADER_CHECKSUM_EN defined: in CHECK the block SHALL accept one extra byte and set err=1 when that byte ≠ the XOR of all data bytes of the load; it SHALL then go to DONE.
- REQ-037 With LOADER_CHECKSUM_EN defined, err SHALL hold its value until the next accepted start or reset.
- REQ-038 Without LOADER_CHECKSUM_EN: the CHECK state and the XOR logic SHALL be absent, err SHALL be tied to 0, and WRITE of the last word SHALL go directly to DONE.

Verification
- REQ-039 Single word: last_addr=0, bytes 0x10..0x18 streamed back-to-back -> one mem_we pulse with addr 0 and wdata 0x101112131415161718; done pulses exactly 11 cycles after start (macro off).
- REQ-040 Three words with byte_valid toggling 1/0 each cycle -> writes at addresses 0, 1, 2 in order with correct data; cpu_hold stays high throughout and drops the cycle after done.
- REQ-041 start pulsed again mid-load -> ignored; last_addr change mid-load has no effect.
- REQ-042 rst asserted after 5 bytes of word 1 -> word 0 was written, no write for word 1; all outputs 0 on the next cycle.
- REQ-043 With LOADER_CHECKSUM_EN defined, word 0x00..0x08 -> checksum byte 0x08 gives err=0 and done; checksum byte 0x09 gives err=1, which holds until the next start.
- REQ-044 last_addr=0xFF (ADDR_W=8) -> 256 writes at addresses 0x00..0xFF; mem_addr does not wrap; exactly one done pulse.
